// File: rtl/axis_config_pkg.sv
// Shared configuration for the host-side byte packer and the matching output-side unpacker.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
// Contents:
//   BYTE_WIDTH  width of one AXI-Stream beat on the host link (8)
//   byte_t      one host-link beat
//   num_bytes() number of whole bytes needed to carry a word of the given width
package axis_config;

    localparam int BYTE_WIDTH = 8;

    typedef logic [BYTE_WIDTH-1:0] byte_t;

    // Rounds up so that a word whose width is not a multiple of 8 still fits.
    function automatic int num_bytes(input int width);
        return (width + BYTE_WIDTH - 1) / BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/axis_byte_packer.sv
// Packs ceil(WORD_WIDTH/8) consecutive host bytes, first byte most significant, into one AXI-Stream word.
// Latency: word valid on the cycle after the edge that accepts its last byte; one byte per cycle sustained.
// Backpressure: one output register; non-final bytes keep flowing while the output stalls, only the final byte waits.
// Ports:
//   clk, arst           rising-edge clock; asynchronous active-high reset
//   clr                 synchronous flush of the partial word and the held output word
//   s_axis_t*           8-bit input byte stream (tdata/tvalid/tready)
//   m_axis_t*           WORD_WIDTH-bit output word stream, driven straight from a register
//   partial             at least one byte of the next word is buffered
module axis_byte_packer
    import axis_config::*;
#(
    parameter int WORD_WIDTH = 24,
    parameter int BYTE_WIDTH = axis_config::BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  clr,
    input  logic [BYTE_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [WORD_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  partial
);

    if (BYTE_WIDTH != 8) begin : g_bad_byte_width
        $error("axis_byte_packer: BYTE_WIDTH must be 8");
    end

    localparam int NUM_BYTES = num_bytes(WORD_WIDTH);
    localparam int CNT_W     = $clog2(NUM_BYTES + 1);
    localparam int ACC_W     = NUM_BYTES * 8;
    // Low bits of the last byte that do not belong to the word.
    localparam int PAD_W     = ACC_W - WORD_WIDTH;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      acc_next;
    logic [CNT_W-1:0]      cnt;
    logic [WORD_WIDTH-1:0] out_q;
    logic                  out_vld;
    logic [WORD_WIDTH-1:0] word_next;
    logic                  is_last;
    logic                  accept;
    logic                  complete;

    // The oldest byte falls off the top; the cast keeps the newest ACC_W bits.
    assign acc_next  = ACC_W'({acc, byte_t'(s_axis_tdata)});
    // Shift the pad bits out before truncating to the MSB-aligned word.
    assign word_next = WORD_WIDTH'(acc_next >> PAD_W);

    assign is_last  = (cnt == LAST_CNT);
    // Only the final byte needs room in the output register; earlier bytes always have room in acc.
    assign s_axis_tready = !clr && (!is_last || !out_vld || m_axis_tready);
    assign accept   = s_axis_tvalid && s_axis_tready;
    assign complete = accept && is_last;

    assign m_axis_tdata  = out_q;
    assign m_axis_tvalid = out_vld;
    assign partial       = (cnt != '0);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            acc     <= '0;
            cnt     <= '0;
            out_q   <= '0;
            out_vld <= 1'b0;
        end else if (clr) begin
            cnt     <= '0;
            out_vld <= 1'b0;
        end else begin
            if (accept) begin
                acc <= acc_next;
                if (is_last) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            // A completing word overwrites out_q even during a handshake, so valid stays up.
            if (complete) begin
                out_q   <= word_next;
                out_vld <= 1'b1;
            end else if (out_vld && m_axis_tready) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_byte_packer.sv
module tb_axis_byte_packer;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        clr = 1'b0;

    // 20-bit instance (three bytes per word, four pad bits)
    logic [7:0]  s_dat = 8'h00;
    logic        s_vld = 1'b0;
    logic        s_rdy;
    logic [19:0] m_dat;
    logic        m_vld;
    logic        m_rdy = 1'b1;
    logic        part;

    // 8-bit instance (one byte per word)
    logic [7:0]  s8_dat = 8'h00;
    logic        s8_vld = 1'b0;
    logic        s8_rdy;
    logic [7:0]  m8_dat;
    logic        m8_vld;
    logic        m8_rdy = 1'b1;
    logic        part8;

    int n_checks = 0;
    int n_errors = 0;
    int n_words  = 0;
    int rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random (>= 75% high)

    logic [19:0] exp_q[$];
    logic [7:0]  mbytes[$];

    always #5 clk = ~clk;

    axis_byte_packer #(.WORD_WIDTH(20)) u_dut20 (
        .clk(clk), .arst(arst), .clr(clr),
        .s_axis_tdata(s_dat), .s_axis_tvalid(s_vld), .s_axis_tready(s_rdy),
        .m_axis_tdata(m_dat), .m_axis_tvalid(m_vld), .m_axis_tready(m_rdy),
        .partial(part)
    );

    axis_byte_packer #(.WORD_WIDTH(8)) u_dut8 (
        .clk(clk), .arst(arst), .clr(1'b0),
        .s_axis_tdata(s8_dat), .s_axis_tvalid(s8_vld), .s_axis_tready(s8_rdy),
        .m_axis_tdata(m8_dat), .m_axis_tvalid(m8_vld), .m_axis_tready(m8_rdy),
        .partial(part8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a word is the first three accepted bytes read as a 24-bit big-endian number,
    // with the four least significant (pad) bits dropped.
    task automatic model_byte(input logic [7:0] b);
        int v;
        mbytes.push_back(b);
        if (mbytes.size() == 3) begin
            v = int'(mbytes[0]) * 65536 + int'(mbytes[1]) * 256 + int'(mbytes[2]);
            exp_q.push_back(20'(v / 16));
            mbytes.delete();
        end
    endtask

    // Downstream ready, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_rdy = 1'b0;
            1:       m_rdy = 1'b1;
            default: m_rdy = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: every presented word must be the oldest expected one; a handshake retires it.
    always @(negedge clk) begin
        if (!arst && m_vld) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_word: got 0x%0h, expected no word", m_dat);
            end else begin
                chk("word", 32'(m_dat), 32'(exp_q[0]));
                if (m_rdy) begin
                    void'(exp_q.pop_front());
                    n_words++;
                end
            end
        end
    end

    // Offers one byte; returns just after the edge that accepts it (or after a timeout).
    task automatic send(input logic [7:0] b);
        int waited = 0;
        s_dat = b;
        s_vld = 1'b1;
        forever begin
            @(negedge clk);
            if (s_rdy) break;
            waited++;
            if (waited > 200) break;
        end
        if (waited > 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: byte 0x%0h not accepted, expected acceptance", b);
            s_vld = 1'b0;
        end else begin
            @(posedge clk);
            model_byte(b);
            #1;
            s_vld = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(posedge clk);
            c++;
        end
        @(posedge clk);
        #1;
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int w0;
        // Reset state
        #12;
        chk("rst_tvalid", 32'(m_vld), 32'd0);
        chk("rst_tdata", 32'(m_dat), 32'd0);
        chk("rst_partial", 32'(part), 32'd0);
        chk("rst_tready", 32'(s_rdy), 32'd1);
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk);
        #1;

        // 1: back-to-back AB CD EF with ready high
        rdy_mode = 1;
        @(posedge clk); #1;
        send(8'hAB);
        send(8'hCD);
        chk("t1_vld_before_last", 32'(m_vld), 32'd0);
        send(8'hEF);
        chk("t1_vld_after_last", 32'(m_vld), 32'd1);
        chk("t1_data", 32'(m_dat), 32'hABCDE);
        @(posedge clk); #1;
        chk("t1_vld_one_cycle", 32'(m_vld), 32'd0);

        // 2: stalled output; non-final bytes still accepted, final one waits
        rdy_mode = 0;
        @(posedge clk); #1;
        send(8'h01);
        send(8'h02);
        send(8'h03);
        chk("t2_held_vld", 32'(m_vld), 32'd1);
        send(8'h04);
        send(8'h05);
        chk("t2_partial", 32'(part), 32'd1);
        chk("t2_held_data", 32'(m_dat), 32'h01020);
        s_dat = 8'h06;
        s_vld = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t2_final_stalled", 32'(s_rdy), 32'd0);
        rdy_mode = 1;
        send(8'h06);
        drain("t2_drained");
        chk("t2_word_count", 32'(n_words), 32'd3);

        // 3: 30 random bytes with random downstream ready
        rdy_mode = 2;
        w0 = n_words;
        for (int i = 0; i < 30; i++) begin
            send(8'($urandom_range(0, 255)));
        end
        drain("t3_drained");
        chk("t3_word_count", 32'(n_words - w0), 32'd10);

        // 4: clr discards a partial word
        rdy_mode = 1;
        @(posedge clk); #1;
        w0 = n_words;
        send(8'hAB);
        send(8'hCD);
        clr = 1'b1;
        @(negedge clk);
        chk("t4_clr_blocks", 32'(s_rdy), 32'd0);
        @(posedge clk);
        mbytes.delete();
        #1;
        clr = 1'b0;
        chk("t4_partial_after_clr", 32'(part), 32'd0);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        drain("t4_drained");
        chk("t4_word_count", 32'(n_words - w0), 32'd1);

        // 5: asynchronous reset with a held word and one buffered byte
        rdy_mode = 0;
        @(posedge clk); #1;
        send(8'h12);
        send(8'h34);
        send(8'h56);
        send(8'h78);
        chk("t5_pending_data", 32'(m_dat), 32'h12345);
        #2;
        arst = 1'b1;
        exp_q.delete();
        mbytes.delete();
        #1;
        chk("t5_async_vld", 32'(m_vld), 32'd0);
        chk("t5_async_partial", 32'(part), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_vld_in_reset", 32'(m_vld), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        rdy_mode = 1;
        @(posedge clk); #1;
        chk("t5_vld_after_release", 32'(m_vld), 32'd0);
        send(8'h77);
        send(8'h88);
        send(8'h99);
        drain("t5_drained");

        // 6: one byte per word
        s8_dat = 8'h5A;
        s8_vld = 1'b1;
        @(negedge clk);
        chk("t6_rdy", 32'(s8_rdy), 32'd1);
        @(posedge clk); #1;
        chk("t6_vld0", 32'(m8_vld), 32'd1);
        chk("t6_data0", 32'(m8_dat), 32'h5A);
        chk("t6_partial0", 32'(part8), 32'd0);
        s8_dat = 8'hA5;
        @(posedge clk); #1;
        s8_vld = 1'b0;
        chk("t6_vld1", 32'(m8_vld), 32'd1);
        chk("t6_data1", 32'(m8_dat), 32'hA5);
        chk("t6_partial1", 32'(part8), 32'd0);
        @(posedge clk); #1;
        chk("t6_vld_end", 32'(m8_vld), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
